// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory request/response and instruction buffer push.
// master = fetch controller, slave = memory/buffer side.
interface fetch_ctrl_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        ib_push_valid;
    logic [31:0] ib_push_pc;
    logic [31:0] ib_push_insn;

    modport master (
        output mem_req_valid, mem_req_addr,
        output ib_push_valid, ib_push_pc, ib_push_insn,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        input  ib_push_valid, ib_push_pc, ib_push_insn,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Credit-limited in-order instruction fetch sequencer feeding the instruction buffer.
// Optional FETCH_CTRL_PERF_EN adds stall-cycle and dropped-response counters.
module fetch_ctrl #(
    parameter int unsigned IBUFFER_SZ      = 8,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash_in,
    input  logic [31:0]        redirect_pc_in,
    input  logic               dispatch_valid_in,
    fetch_ctrl_if.master       bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_dropped_rsp
`endif
);

    localparam int OCC_W = $clog2(IBUFFER_SZ) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SUM_W = ((OCC_W > OUT_W) ? OCC_W : OUT_W) + 1;
    localparam logic [OCC_W-1:0] OCC_ONE = 1;
    localparam logic [OUT_W-1:0] OUT_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           fsm;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [OCC_W-1:0] occ;
    logic [OUT_W-1:0] outst;

    logic             credit_ok;
    logic             req_valid;
    logic             push_valid;
    logic             accept;
    logic             dispatch_dec;
    logic [OCC_W-1:0] occ_next;
    logic [OUT_W-1:0] outst_next;

    // Credits cover both buffered and in-flight words so the buffer can never overflow.
    always_comb begin
        credit_ok    = ((SUM_W'(occ) + SUM_W'(outst)) < SUM_W'(IBUFFER_SZ)) &&
                       (outst < OUT_W'(MAX_OUTSTANDING));
        req_valid    = reset && (fsm == RUN) && !squash_in && credit_ok;
        push_valid   = reset && (fsm == RUN) && !squash_in && bus.mem_rsp_valid;
        accept       = req_valid && bus.mem_req_ready;
        dispatch_dec = dispatch_valid_in && (occ != '0);

        occ_next = occ;
        if (push_valid && !dispatch_dec) begin
            occ_next = occ + OCC_ONE;
        end else if (!push_valid && dispatch_dec) begin
            occ_next = occ - OCC_ONE;
        end

        outst_next = outst;
        if (accept && !(bus.mem_rsp_valid && (outst != '0))) begin
            outst_next = outst + OUT_ONE;
        end else if (!accept && bus.mem_rsp_valid && (outst != '0)) begin
            outst_next = outst - OUT_ONE;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.ib_push_valid = push_valid;
    assign bus.ib_push_pc    = rsp_pc;
    assign bus.ib_push_insn  = push_valid ? bus.mem_rsp_data : 32'h0;

    // Squash reloads both PCs and parks in DRAIN until every stale response has returned.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm      <= IDLE;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            occ      <= '0;
            outst    <= '0;
        end else begin
            outst <= outst_next;
            if (squash_in) begin
                fetch_pc <= redirect_pc_in & ~32'h3;
                rsp_pc   <= redirect_pc_in & ~32'h3;
                occ      <= '0;
                fsm      <= (outst_next != '0) ? DRAIN : RUN;
            end else begin
                occ <= occ_next;
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push_valid) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                case (fsm)
                    IDLE:    fsm <= RUN;
                    RUN:     fsm <= RUN;
                    DRAIN:   if (outst_next == '0) fsm <= RUN;
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall_cycles <= 32'h0;
            perf_dropped_rsp  <= 32'h0;
        end else begin
            if ((fsm == RUN) && !squash_in && !credit_ok) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bus.mem_rsp_valid && (squash_in || (fsm == DRAIN))) begin
                perf_dropped_rsp <= perf_dropped_rsp + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a credit/stale-count reference model.
module tb_fetch_ctrl;

    localparam int          IB_SZ   = 8;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } req_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash_in;
    logic [31:0] redirect_pc_in;
    logic        dispatch_valid_in;

    fetch_ctrl_if bus();

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dropped_rsp;
`endif

    fetch_ctrl #(
        .IBUFFER_SZ      (IB_SZ),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .squash_in         (squash_in),
        .redirect_pc_in    (redirect_pc_in),
        .dispatch_valid_in (dispatch_valid_in),
        .bus               (bus)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dropped_rsp  (perf_dropped_rsp)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch stream, buffer count, in-flight words and how many of them are stale.
    req_t        mem_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_rsp_pc;
    int          m_occ;
    int          stale;
    int          m_dropped;
    bit          first_cyc;
    int          cycle = 0;
    int          dut_pushes;
    int          dut_reqs;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic modelReset();
        m_fetch_pc = RST_PC;
        m_rsp_pc   = RST_PC;
        m_occ      = 0;
        stale      = 0;
        first_cyc  = 1'b1;
        mem_q.delete();
    endtask

    task automatic applyStimulus(input logic sq, input logic [31:0] rpc, input logic disp,
                                 input logic rdy, input logic rsp_en, input logic rst_n);
        logic        disp_eff;
        logic        rsp;
        logic        exp_req;
        logic        exp_push;
        logic [31:0] rdata;
        int          inflight;
        req_t        ent;
        @(negedge clock);
        disp_eff          = disp && (m_occ > 0);
        rsp               = rst_n && rsp_en && (mem_q.size() > 0) && (mem_q[0].cyc < cycle);
        rdata             = rsp ? mem_q[0].data : $urandom;
        reset             = rst_n;
        squash_in         = sq;
        redirect_pc_in    = rpc;
        dispatch_valid_in = disp_eff;
        bus.mem_req_ready = rdy;
        bus.mem_rsp_valid = rsp;
        bus.mem_rsp_data  = rdata;
        #1;
        inflight = mem_q.size();
        if (!rst_n) begin
            exp_req  = 1'b0;
            exp_push = 1'b0;
        end else begin
            exp_req  = !first_cyc && (stale == 0) && !sq &&
                       (m_occ + inflight < IB_SZ) && (inflight < MAX_OUT);
            exp_push = rsp && !sq && (stale == 0);
        end

        checkOutput("req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
        checkOutput("req_addr", bus.mem_req_addr, m_fetch_pc);
        checkOutput("push_valid", 32'(bus.ib_push_valid), 32'(exp_push));
        checkOutput("push_pc", bus.ib_push_pc, m_rsp_pc);
        if (exp_push) checkOutput("push_insn", bus.ib_push_insn, rdata);
        else if (!rst_n) checkOutput("reset_insn", bus.ib_push_insn, 32'h0);
        if (bus.ib_push_valid === 1'b1) dut_pushes++;
        if (bus.mem_req_valid === 1'b1) dut_reqs++;

        if (!rst_n) begin
            modelReset();
            m_dropped = 0;
        end else begin
            if (rsp && (sq || stale > 0)) m_dropped++;
            if (rsp) void'(mem_q.pop_front());
            if (sq) begin
                m_fetch_pc = rpc & ~32'h3;
                m_rsp_pc   = rpc & ~32'h3;
                m_occ      = 0;
                stale      = mem_q.size();
            end else begin
                if (rsp && stale > 0) stale--;
                if (disp_eff) m_occ--;
                if (exp_push) begin
                    m_rsp_pc = m_rsp_pc + 32'd4;
                    m_occ++;
                end
                if (exp_req && rdy) begin
                    ent.addr = m_fetch_pc;
                    ent.data = $urandom;
                    ent.cyc  = cycle;
                    mem_q.push_back(ent);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
            first_cyc = 1'b0;
        end
        cycle++;
    endtask

    initial begin
        reset             = 1'b0;
        squash_in         = 1'b0;
        redirect_pc_in    = 32'h0;
        dispatch_valid_in = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        m_dropped         = 0;
        modelReset();
        repeat (2) @(posedge clock);

        $display("[TB] reset and initial fill");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        dut_pushes = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("fill_push_count", 32'(dut_pushes), 32'd8);

        $display("[TB] single credit release");
        dut_reqs = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("release_req_count", 32'(dut_reqs), 32'd1);

        $display("[TB] request stall");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("[TB] squash with two in flight");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1002, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("[TB] squash coincident with response");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("[TB] reset during drain");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) < 4, $urandom,
                          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 70, $urandom_range(0, 299) != 0);
        end

`ifdef FETCH_CTRL_PERF_EN
        @(negedge clock);
        checkOutput("perf_dropped_rsp", perf_dropped_rsp, 32'(m_dropped));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch into the instruction buffer.
- Issues in-order word fetches to instruction memory and forwards returned instructions to the buffer as push packets.
- Uses credit accounting (buffer occupancy + in-flight fetches) so the buffer never overflows.
- On squash, redirects the PC and discards stale in-flight responses before fetching resumes.

Parameters:
IBUFFER_SZ, 8, instruction buffer depth; must match the buffer instance
MAX_OUTSTANDING, 2, max fetches in flight (1..4)
RESET_PC, 32'h0, PC loaded at reset

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clock)
squash_in  input  1  pipeline flush; clears the buffer in the same cycle
redirect_pc_in  input  32  new fetch PC, valid when squash_in=1
dispatch_valid_in  input  1  buffer head consumed this cycle
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  32  fetch address, word aligned
mem_req_ready  input  1  memory accepts request
mem_rsp_valid  input  1  in-order response valid; cannot be back-pressured
mem_rsp_data  input  32  instruction word
ib_push_valid  output  1  push one instruction into the buffer
ib_push_pc  output  32  PC of pushed instruction
ib_push_insn  output  32  pushed instruction

Behaviour:
- State: fsm {IDLE, RUN, DRAIN}; fetch_pc[31:0]; rsp_pc[31:0]; occ[$clog2(IBUFFER_SZ):0]; outst[$clog2(MAX_OUTSTANDING):0].
- Reset (reset==0 at posedge):
  - fsm=IDLE; fetch_pc=rsp_pc=RESET_PC; occ=0; outst=0.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, ib_push_valid=0, ib_push_pc=RESET_PC, ib_push_insn=0.
  - Reset wins over all other inputs.
- IDLE:
  - One cycle, no requests; then RUN.
- RUN, issue:
  - mem_req_valid = !squash_in && (occ+outst < IBUFFER_SZ) && (outst < MAX_OUTSTANDING).
  - mem_req_addr = fetch_pc.
  - Accept = valid && ready → fetch_pc += 4 (mod 2^32), outst += 1.
  - Address is held stable while valid && !ready. Valid may drop only on squash or reset.
- RUN, response:
  - ib_push_valid = mem_rsp_valid && !squash_in, combinational, same cycle.
  - ib_push_pc = rsp_pc; ib_push_insn = mem_rsp_data.
  - On push: rsp_pc += 4, occ += 1.
  - Any mem_rsp_valid: outst -= 1.
- Occupancy:
  - dispatch_valid_in: occ -= 1.
  - Push and dispatch in the same cycle: occ unchanged.
  - dispatch_valid_in with occ==0 is illegal; occ saturates at 0.
- Squash (any state, not in reset):
  - fetch_pc = rsp_pc = redirect_pc_in & ~32'h3; occ = 0.
  - No request or push that cycle.
  - A response arriving that cycle is dropped but still decrements outst.
  - Next state = DRAIN if post-update outst > 0, else RUN.
- DRAIN:
  - mem_req_valid = 0; every response is dropped and decrements outst.
  - When outst reaches 0 (including this cycle's response) → RUN next cycle.
  - A squash in DRAIN reloads PCs and remains in DRAIN if outst > 0.
- Invariant: occ + outst <= IBUFFER_SZ at all times.
- Credit release: dispatch releases its credit in the same cycle; the freed slot can be requested the next cycle.

Optional Feature:
FETCH_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_dropped_rsp[31:0].
  - perf_stall_cycles counts RUN cycles without squash in which the credit condition blocks mem_req_valid.
  - perf_dropped_rsp counts responses discarded by squash or DRAIN.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then mem_req_ready=1 with responses 1 cycle later → IDLE 1 cycle; requests to 0x0,0x4,0x8…; pushes with matching PCs, never exceeding MAX_OUTSTANDING=2 in flight.
- No dispatch, continuous ready/responses → exactly 8 pushes, then mem_req_valid stays 0. One dispatch_valid_in → exactly one more request (addr 0x20).
- mem_req_ready=0 for 3 cycles → mem_req_addr held at the same value, mem_req_valid=1 throughout, fetch_pc not advanced.
- Squash with redirect 0x1002 while outst=2 → DRAIN. Next two responses give ib_push_valid=0. First request afterwards has addr 0x1000, and the push PC is 0x1000.
- Squash coincident with mem_rsp_valid and outst=1 → response dropped, next state RUN, request to redirect PC the following cycle.
- Push and dispatch in the same cycle at occ=8-1 → occ unchanged. Reset asserted mid-DRAIN → all state returns to reset values next cycle. With FETCH_CTRL_PERF_EN defined, perf_dropped_rsp equals the number of dropped responses.
